// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the RV32I core.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes
// with instruction and data memory. It also drives the IR/PC/register-file
// write strobes, counts retired instructions and latches a sticky trap on an
// illegal opcode or a memory timeout. The datapath selects come from the
// combinational decoder; this block only decides in which cycle they apply.
module multicycle_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             reg_we,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // Instruction class latched in DECODE; selects the path through EXEC/MEM/WB.
    typedef enum logic [2:0] {
        CLS_NONE    = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_JUMP    = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_LOAD    = 3'd4,
        CLS_STORE   = 3'd5,
        CLS_FENCE   = 3'd6,
        CLS_ILLEGAL = 3'd7
    } cls_t;

    // Timeout fires when the counter sits at MEM_TIMEOUT-1 with ready still low.
    localparam bit              TO_EN   = (MEM_TIMEOUT != 32'd0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 32'd1);

    // Opcode to class map; SYSTEM and every unlisted opcode are illegal.
    function automatic cls_t classify(input logic [6:0] opc);
        cls_t c;
        case (opc)
            7'b0110111, 7'b0010111,
            7'b0110011, 7'b0010011: c = CLS_ALU;
            7'b1101111, 7'b1100111: c = CLS_JUMP;
            7'b1100011:             c = CLS_BRANCH;
            7'b0000011:             c = CLS_LOAD;
            7'b0100011:             c = CLS_STORE;
            7'b0001111:             c = CLS_FENCE;
            default:                c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    cls_t              cls_r;
    cls_t              cls_nxt_s;
    logic [TO_W-1:0]   wait_cnt_r;
    logic              req_wait_s;
    logic              timeout_s;
    logic              retire_s;
    logic              trap_set_s;
    logic [1:0]        trap_cause_nxt_s;
    logic [CNT_W-1:0]  instret_r;
    logic              trap_r;
    logic [1:0]        trap_cause_r;

    assign timeout_s  = TO_EN && (wait_cnt_r == TO_LAST);
    assign state      = state_r;
    assign instret    = instret_r;
    assign trap       = trap_r;
    assign trap_cause = trap_cause_r;

    // Next-state and Moore outputs, with ready gating only on handshake completion.
    always_comb begin
        state_nxt_s      = state_r;
        cls_nxt_s        = cls_r;
        imem_req         = 1'b0;
        dmem_req         = 1'b0;
        dmem_we          = 1'b0;
        ir_we            = 1'b0;
        pc_we            = 1'b0;
        pc_sel           = 1'b0;
        reg_we           = 1'b0;
        retire_s         = 1'b0;
        req_wait_s       = 1'b0;
        trap_set_s       = 1'b0;
        trap_cause_nxt_s = trap_cause_r;
        case (state_r)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we       = 1'b1;
                    state_nxt_s = S_DECODE;
                end else begin
                    req_wait_s = 1'b1;
                    if (timeout_s) begin
                        state_nxt_s      = S_TRAP;
                        trap_set_s       = 1'b1;
                        trap_cause_nxt_s = 2'b10;
                    end else begin
                        state_nxt_s = S_FETCH;
                    end
                end
            end
            S_DECODE: begin
                cls_nxt_s = classify(opcode);
                if (cls_nxt_s == CLS_ILLEGAL) begin
                    state_nxt_s      = S_TRAP;
                    trap_set_s       = 1'b1;
                    trap_cause_nxt_s = 2'b01;
                end else begin
                    state_nxt_s = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_r)
                    CLS_LOAD, CLS_STORE: state_nxt_s = S_MEM;
                    CLS_BRANCH: begin
                        pc_we       = 1'b1;
                        pc_sel      = branch_taken;
                        retire_s    = 1'b1;
                        state_nxt_s = S_FETCH;
                    end
                    CLS_FENCE: begin
                        pc_we       = 1'b1;
                        retire_s    = 1'b1;
                        state_nxt_s = S_FETCH;
                    end
                    default: state_nxt_s = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_r == CLS_STORE);
                if (dmem_ready) begin
                    if (cls_r == CLS_STORE) begin
                        pc_we       = 1'b1;
                        retire_s    = 1'b1;
                        state_nxt_s = S_FETCH;
                    end else begin
                        state_nxt_s = S_WB;
                    end
                end else begin
                    req_wait_s = 1'b1;
                    if (timeout_s) begin
                        state_nxt_s      = S_TRAP;
                        trap_set_s       = 1'b1;
                        trap_cause_nxt_s = 2'b11;
                    end else begin
                        state_nxt_s = S_MEM;
                    end
                end
            end
            S_WB: begin
                reg_we      = 1'b1;
                pc_we       = 1'b1;
                pc_sel      = (cls_r == CLS_JUMP);
                retire_s    = 1'b1;
                state_nxt_s = S_FETCH;
            end
            S_TRAP: state_nxt_s = S_TRAP;
            default: state_nxt_s = S_FETCH;
        endcase
    end

    // State and latched instruction class.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
            cls_r   <= CLS_NONE;
        end else begin
            state_r <= state_nxt_s;
            cls_r   <= cls_nxt_s;
        end
    end

    // Consecutive wait-cycle counter; any non-waiting cycle clears it, so entry to FETCH/MEM starts at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_r <= {TO_W{1'b0}};
        end else if (req_wait_s) begin
            wait_cnt_r <= wait_cnt_r + TO_W'(1);
        end else begin
            wait_cnt_r <= {TO_W{1'b0}};
        end
    end

    // Retired-instruction counter, wrapping naturally at its width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            instret_r <= instret_r + CNT_W'(1);
        end else begin
            instret_r <= instret_r;
        end
    end

    // Sticky trap flag and cause; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trap_r       <= 1'b0;
            trap_cause_r <= 2'b00;
        end else begin
            trap_r       <= trap_r | trap_set_s;
            trap_cause_r <= trap_cause_nxt_s;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer.
// The DUT runs with MEM_TIMEOUT=4 and CNT_W=4 so the timeout and wrap cases are short.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       imem_req;
    logic       imem_ready;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ready;
    logic       ir_we;
    logic       pc_we;
    logic       pc_sel;
    logic       reg_we;
    logic [2:0] state;
    logic [3:0] instret;
    logic       trap;
    logic [1:0] trap_cause;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_FNC  = 7'b0001111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    // {state, imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, reg_we}
    localparam logic [9:0] F_WAIT   = {3'd0, 7'b1000000};
    localparam logic [9:0] F_GO     = {3'd0, 7'b1100000};
    localparam logic [9:0] DEC      = {3'd1, 7'b0000000};
    localparam logic [9:0] EX_IDLE  = {3'd2, 7'b0000000};
    localparam logic [9:0] EX_BR_T  = {3'd2, 7'b0000110};
    localparam logic [9:0] EX_PC4   = {3'd2, 7'b0000100};
    localparam logic [9:0] MEM_LD   = {3'd3, 7'b0010000};
    localparam logic [9:0] MEM_STW  = {3'd3, 7'b0011000};
    localparam logic [9:0] MEM_STGO = {3'd3, 7'b0011100};
    localparam logic [9:0] WB_PC4   = {3'd4, 7'b0000101};
    localparam logic [9:0] WB_JMP   = {3'd4, 7'b0000111};
    localparam logic [9:0] TRAPPED  = {3'd5, 7'b0000000};

    logic [9:0] obs;
    assign obs = {state, imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, reg_we};

    multicycle_sequencer #(
        .MEM_TIMEOUT(4),
        .TO_W(8),
        .CNT_W(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .reg_we       (reg_we),
        .state        (state),
        .instret      (instret),
        .trap         (trap),
        .trap_cause   (trap_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check this cycle's outputs, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [9:0] exp);
        #1;
        check(tag, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    // One reset edge.
    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        opcode       = OP_ADD;
        branch_taken = 1'b0;
        imem_ready   = 1'b0;
        dmem_ready   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_state",   32'(state), 32'd0);
        check("rst_instret", 32'(instret), 32'd0);
        check("rst_trap",    32'(trap), 32'd0);
        check("rst_cause",   32'(trap_cause), 32'd0);
        check("rst_outputs", 32'(obs), 32'(F_WAIT));

        // ADD, zero-wait; branch_taken high must not leak into pc_sel in WB
        imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b1; opcode = OP_ADD;
        step("add_f", F_GO); step("add_d", DEC); step("add_e", EX_IDLE); step("add_wb", WB_PC4);
        check("add_instret", 32'(instret), 32'd1);
        branch_taken = 1'b0;

        // LW with three wait cycles; ready arrives with the counter at its last value
        opcode = OP_LW; dmem_ready = 1'b0;
        step("lw_f", F_GO); step("lw_d", DEC); step("lw_e", EX_IDLE);
        for (int i = 0; i < 3; i++) step("lw_mem_wait", MEM_LD);
        dmem_ready = 1'b1;
        step("lw_mem_go", MEM_LD); step("lw_wb", WB_PC4);
        check("lw_instret", 32'(instret), 32'd2);
        check("lw_no_trap", 32'(trap), 32'd0);

        // SW zero-wait
        opcode = OP_SW;
        step("sw_f", F_GO); step("sw_d", DEC); step("sw_e", EX_IDLE); step("sw_mem", MEM_STGO);
        check("sw_instret", 32'(instret), 32'd3);

        // BEQ taken then not taken
        opcode = OP_BEQ; branch_taken = 1'b1;
        step("beq_t_f", F_GO); step("beq_t_d", DEC); step("beq_t_e", EX_BR_T);
        branch_taken = 1'b0;
        step("beq_n_f", F_GO); step("beq_n_d", DEC); step("beq_n_e", EX_PC4);
        check("beq_instret", 32'(instret), 32'd5);

        // JAL takes the target in WB; FENCE retires from EXEC
        opcode = OP_JAL;
        step("jal_f", F_GO); step("jal_d", DEC); step("jal_e", EX_IDLE); step("jal_wb", WB_JMP);
        opcode = OP_FNC;
        step("fnc_f", F_GO); step("fnc_d", DEC); step("fnc_e", EX_PC4);
        check("fnc_instret", 32'(instret), 32'd7);

        // SW with data memory never ready: dmem_we held, timeout trap cause 11
        opcode = OP_SW; dmem_ready = 1'b0;
        step("dto_f", F_GO); step("dto_d", DEC); step("dto_e", EX_IDLE);
        for (int i = 0; i < 4; i++) step("dto_mem_wait", MEM_STW);
        step("dto_trap", TRAPPED);
        check("dto_flag",    32'(trap), 32'd1);
        check("dto_cause",   32'(trap_cause), 32'd3);
        check("dto_instret", 32'(instret), 32'd7);
        do_reset();
        check("dto_rst_instret", 32'(instret), 32'd0);

        // Fetch never ready: trap cause 10 after four request cycles
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("ito_f_wait", F_WAIT);
        step("ito_trap", TRAPPED);
        check("ito_flag",  32'(trap), 32'd1);
        check("ito_cause", 32'(trap_cause), 32'd2);
        do_reset();
        check("ito_rst_trap", 32'(trap), 32'd0);

        // Ready in the fourth request cycle wins over the timeout
        opcode = OP_ADD;
        for (int i = 0; i < 3; i++) step("rdy4_f_wait", F_WAIT);
        imem_ready = 1'b1;
        step("rdy4_f_go", F_GO); step("rdy4_d", DEC);
        check("rdy4_no_trap", 32'(trap), 32'd0);
        step("rdy4_e", EX_IDLE); step("rdy4_wb", WB_PC4);
        check("rdy4_instret", 32'(instret), 32'd1);

        // SYSTEM opcode is illegal; TRAP ignores all later input activity
        opcode = OP_SYS;
        step("ill_f", F_GO); step("ill_d", DEC);
        check("ill_flag",  32'(trap), 32'd1);
        check("ill_cause", 32'(trap_cause), 32'd1);
        opcode = OP_ADD; dmem_ready = 1'b1; branch_taken = 1'b1;
        step("ill_hold0", TRAPPED);
        imem_ready = 1'b0; opcode = OP_SW;
        step("ill_hold1", TRAPPED);
        imem_ready = 1'b1; dmem_ready = 1'b0; opcode = OP_BEQ;
        step("ill_hold2", TRAPPED);
        check("ill_cause_held", 32'(trap_cause), 32'd1);
        check("ill_instret",    32'(instret), 32'd1);
        do_reset();
        #1;
        check("ill_rst_state",   32'(state), 32'd0);
        check("ill_rst_trap",    32'(trap), 32'd0);
        check("ill_rst_cause",   32'(trap_cause), 32'd0);
        check("ill_rst_instret", 32'(instret), 32'd0);

        // Reset in the middle of a pending load
        branch_taken = 1'b0; opcode = OP_LW; dmem_ready = 1'b0;
        step("mid_f", F_GO); step("mid_d", DEC); step("mid_e", EX_IDLE);
        rst_n = 1'b0;
        step("mid_mem", MEM_LD);
        rst_n = 1'b1; imem_ready = 1'b0;
        step("mid_after_rst", F_WAIT);

        // Sixteen FENCEs wrap the 4-bit counter 15 -> 0
        imem_ready = 1'b1; opcode = OP_FNC;
        for (int i = 0; i < 16; i++) begin
            step("wrap_f", F_GO); step("wrap_d", DEC); step("wrap_e", EX_PC4);
            check("wrap_instret", 32'(instret), 32'((i + 1) % 16));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Handshakes with instruction and data memory, and drives the write enables for the IR, PC and register file.
- Sits beside the combinational control decoder: the decoder supplies the ALU/mux selects, and this block decides in which cycle they take effect.
- Also counts retired instructions and traps on illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 255: maximum consecutive wait cycles (req=1, ready=0) before a timeout trap; 0 disables the timeout.
- TO_W, 8: width of the wait counter; must satisfy MEM_TIMEOUT < 2^TO_W.
- CNT_W, 32: width of instret.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- opcode  in  7  instr[6:0] from the IR; valid from the DECODE cycle onward.
- branch_taken  in  1  branch-condition result; sampled in EXEC.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid this cycle.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; meaningful only while dmem_req=1.
- dmem_ready  in  1  data access complete this cycle.
- ir_we  out  1  IR load strobe.
- pc_we  out  1  PC update strobe.
- pc_sel  out  1  0 = PC+4, 1 = ALU/branch target.
- reg_we  out  1  register-file write strobe.
- state  out  3  current state, for debug.
- instret  out  CNT_W  retired-instruction count.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  01 illegal opcode, 10 imem timeout, 11 dmem timeout.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 recover to FETCH on the next edge.
- Reset (synchronous, rst_n=0 at a clock edge, any state, including mid-handshake):
  - state=FETCH; instret=0; trap=0; trap_cause=0; wait counter=0; latched class cleared.
  - All request and strobe outputs deassert from the cycle after that edge.
- Outputs are Moore-decoded from the registered state plus the latched class, with ready gating only where stated below. Strobes are 1-cycle pulses.
- FETCH:
  - imem_req=1.
  - If imem_ready=1 in this cycle: ir_we=1, go to DECODE. Ready in the first request cycle is accepted (zero wait).
- DECODE:
  - Classify opcode and latch the class.
  - Legal opcodes: LUI 0110111, AUIPC 0010111, OP 0110011, OP-IMM 0010011, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, FENCE 0001111.
  - Any other opcode (SYSTEM included) goes to TRAP with cause 01; otherwise go to EXEC.
- EXEC (1 cycle):
  - LOAD/STORE: go to MEM.
  - BRANCH: pc_we=1, pc_sel=branch_taken, retire, go to FETCH.
  - FENCE: pc_we=1, pc_sel=0, retire, go to FETCH (treated as a no-op).
  - All other classes: go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE.
  - On dmem_ready=1: STORE does pc_we=1, pc_sel=0, retire, go to FETCH; LOAD goes to WB.
  - dmem_req/dmem_we are held stable until ready is seen.
- WB:
  - reg_we=1, pc_we=1, retire, go to FETCH.
  - pc_sel=1 for JAL/JALR, 0 otherwise.
- Retire means instret increments by 1 on the same edge and wraps modulo 2^CNT_W.
- Wait counter:
  - Cleared on entry to FETCH or MEM and whenever ready=1.
  - Increments each cycle the state requests and ready=0.
  - If MEM_TIMEOUT≠0 and the counter equals MEM_TIMEOUT-1 while ready=0, go to TRAP: cause 10 from FETCH, 11 from MEM.
  - Ready=1 in that same cycle wins; no trap.
- TRAP:
  - trap=1; all requests and strobes are 0; trap_cause is held.
  - Only reset exits TRAP.
  - No retire, and the PC is not written on the trap path.
- Ready inputs are ignored in any state that is not requesting.
- branch_taken is ignored outside EXEC with class BRANCH.
- Latency with zero-wait memory, in cycles from FETCH entry to the next FETCH entry:
  - ALU/U-type/JAL/JALR: 4.
  - LOAD: 5.
  - STORE: 4.
  - BRANCH/FENCE: 3.
  - Each memory wait cycle adds 1.

Test Plan:
- Reset, then ADD (0110011), ready tied high → state sequence 0,1,2,4,0; ir_we in cycle 0, reg_we and pc_we in cycle 3 with pc_sel=0; instret=1 after 4 cycles.
- LW (0000011) with dmem_ready delayed 3 cycles → dmem_req=1 and dmem_we=0 held for 4 cycles, then WB with reg_we=1; total 8 cycles. SW (0100011) with ready high → no reg_we, pc_we in the MEM cycle, 4 cycles.
- BEQ (1100011) with branch_taken=1, then again with 0 → pc_we in EXEC with pc_sel=1, then 0; reg_we never asserted; instret +2 after 6 cycles.
- Opcode 1110011 → TRAP after DECODE, trap=1, cause=01; later ready pulses and opcode changes produce no output activity; rst_n=0 for 1 edge → FETCH, trap=0, instret=0.
- MEM_TIMEOUT=4, imem_ready held 0 → TRAP with cause 10 after 4 request cycles. Repeat with ready=1 in the 4th cycle → DECODE, no trap.
- rst_n asserted mid-MEM with dmem_req=1 → dmem_req=0 the cycle after the edge, state=FETCH; run 2^CNT_W retires with CNT_W=4 → instret wraps 15→0.
